// File: rtl/ascii2bin_parser_pkg.sv
// Shared keyboard-path definitions: ASCII constants and the hex-entry parser states.
package ascii2bin_parser_pkg;

  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_BS  = 8'h08;
  localparam logic [7:0] CHAR_ESC = 8'h1B;
  localparam logic [7:0] CHAR_0   = 8'h30;
  localparam logic [7:0] CHAR_A   = 8'h41;
  localparam logic [7:0] CHAR_a   = 8'h61;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_ENTRY    = 2'd1,
    ST_OVERFLOW = 2'd2
  } state_t;

endpackage

// File: rtl/ascii2bin_parser_decode.sv
// Combinational ASCII classifier: hex digit to nibble, plus terminator/backspace/escape flags.
module ascii_hex_decode
  import ascii2bin_parser_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR = CHAR_CR,
  parameter logic [7:0] BKSP_CHAR = CHAR_BS,
  parameter logic [7:0] ESC_CHAR  = CHAR_ESC
) (
  input  logic [7:0] char_in,
  output logic       is_digit,
  output logic [3:0] nibble,
  output logic       is_term,
  output logic       is_bksp,
  output logic       is_esc,
  output logic       is_illegal
);

  always_comb begin
    is_digit = 1'b0;
    nibble   = '0;
    if (char_in >= CHAR_0 && char_in <= CHAR_0 + 8'd9) begin
      is_digit = 1'b1;
      nibble   = 4'(char_in - CHAR_0);
    end else if (char_in >= CHAR_A && char_in <= CHAR_A + 8'd5) begin
      is_digit = 1'b1;
      nibble   = 4'(char_in - CHAR_A + 8'd10);
    end else if (char_in >= CHAR_a && char_in <= CHAR_a + 8'd5) begin
      is_digit = 1'b1;
      nibble   = 4'(char_in - CHAR_a + 8'd10);
    end
  end

  // Digits take precedence should a control character ever be remapped onto one.
  assign is_term    = !is_digit && (char_in == TERM_CHAR);
  assign is_bksp    = !is_digit && (char_in == BKSP_CHAR);
  assign is_esc     = !is_digit && (char_in == ESC_CHAR);
  assign is_illegal = !(is_digit || is_term || is_bksp || is_esc);

endmodule

// File: rtl/ascii2bin_parser.sv
// Accumulates up to NDIGITS ASCII hex digits into a binary word; commits on the terminator.
module ascii2bin_parser
  import ascii2bin_parser_pkg::*;
#(
  parameter int         NDIGITS   = 4,
  parameter logic [7:0] TERM_CHAR = CHAR_CR,
  parameter logic [7:0] BKSP_CHAR = CHAR_BS,
  parameter logic [7:0] ESC_CHAR  = CHAR_ESC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             char_in,
  input  logic                   char_valid,
  output logic [4*NDIGITS-1:0]   value,
  output logic                   value_valid,
  output logic                   err,
  output logic [4*NDIGITS-1:0]   partial,
  output logic [2:0]             digit_cnt
);

  localparam int         W      = 4 * NDIGITS;
  localparam logic [2:0] MAXCNT = 3'(NDIGITS);

  logic       is_digit;
  logic [3:0] nibble;
  logic       is_term;
  logic       is_bksp;
  logic       is_esc;
  logic       is_illegal;
  state_t     state;

  ascii_hex_decode #(
    .TERM_CHAR(TERM_CHAR),
    .BKSP_CHAR(BKSP_CHAR),
    .ESC_CHAR (ESC_CHAR)
  ) u_decode (
    .char_in   (char_in),
    .is_digit  (is_digit),
    .nibble    (nibble),
    .is_term   (is_term),
    .is_bksp   (is_bksp),
    .is_esc    (is_esc),
    .is_illegal(is_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_EMPTY;
      value       <= '0;
      value_valid <= 1'b0;
      err         <= 1'b0;
      partial     <= '0;
      digit_cnt   <= '0;
    end else begin
      value_valid <= 1'b0;
      err         <= 1'b0;
      if (char_valid) begin
        unique case (state)
          ST_EMPTY: begin
            if (is_digit) begin
              partial   <= W'(nibble);
              digit_cnt <= 3'd1;
              state     <= ST_ENTRY;
            end else if (is_illegal) begin
              err <= 1'b1;
            end
          end
          ST_ENTRY: begin
            if (is_digit) begin
              if (digit_cnt < MAXCNT) begin
                partial   <= (partial << 4) | W'(nibble);
                digit_cnt <= digit_cnt + 3'd1;
              end else begin
                state <= ST_OVERFLOW;
              end
            end else if (is_bksp) begin
              partial   <= partial >> 4;
              digit_cnt <= digit_cnt - 3'd1;
              if (digit_cnt == 3'd1) state <= ST_EMPTY;
            end else if (is_term) begin
              value       <= partial;
              value_valid <= 1'b1;
              partial     <= '0;
              digit_cnt   <= '0;
              state       <= ST_EMPTY;
            end else if (is_esc) begin
              partial   <= '0;
              digit_cnt <= '0;
              state     <= ST_EMPTY;
            end else begin
              err <= 1'b1;
            end
          end
          ST_OVERFLOW: begin
            // partial/digit_cnt stay frozen until the entry is closed.
            if (is_term || is_esc) begin
              err       <= is_term;
              partial   <= '0;
              digit_cnt <= '0;
              state     <= ST_EMPTY;
            end else if (is_illegal) begin
              err <= 1'b1;
            end
          end
          default: state <= ST_EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ascii2bin_parser.sv
// Directed bench for ascii2bin_parser with hand-computed expectations.
module tb_ascii2bin_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  char_in;
  logic        char_valid;
  logic [15:0] value;
  logic        value_valid;
  logic        err;
  logic [15:0] partial;
  logic [2:0]  digit_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  ascii2bin_parser #(
    .NDIGITS  (4),
    .TERM_CHAR(8'h0D),
    .BKSP_CHAR(8'h08),
    .ESC_CHAR (8'h1B)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .value      (value),
    .value_valid(value_valid),
    .err        (err),
    .partial    (partial),
    .digit_cnt  (digit_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one character for one cycle, then check the registered outputs.
  task automatic step(input string tag, input logic [7:0] c, input logic [15:0] exp_partial,
                      input logic [2:0] exp_cnt, input logic exp_vv, input logic exp_err);
    char_in    = c;
    char_valid = 1'b1;
    @(negedge clk);
    check({tag, ".partial"}, 32'(partial), 32'(exp_partial));
    check({tag, ".cnt"}, 32'(digit_cnt), 32'(exp_cnt));
    check({tag, ".vv"}, 32'(value_valid), 32'(exp_vv));
    check({tag, ".err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic idle(input string tag);
    char_valid = 1'b0;
    char_in    = 8'h00;
    @(negedge clk);
    check({tag, ".vv_idle"}, 32'(value_valid), 32'd0);
    check({tag, ".err_idle"}, 32'(err), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    char_in    = 8'h00;
    char_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.value", 32'(value), 32'h0);
    check("rst.partial", 32'(partial), 32'h0);
    check("rst.cnt", 32'(digit_cnt), 32'h0);
    check("rst.vv", 32'(value_valid), 32'h0);
    check("rst.err", 32'(err), 32'h0);
    rst = 1'b0;
    idle("rst");

    // basic entry, mixed case
    step("t1.1", "1",  16'h0001, 3'd1, 1'b0, 1'b0);
    step("t1.a", "a",  16'h001A, 3'd2, 1'b0, 1'b0);
    step("t1.F", "F",  16'h01AF, 3'd3, 1'b0, 1'b0);
    step("t1.3", "3",  16'h1AF3, 3'd4, 1'b0, 1'b0);
    step("t1.cr", 8'h0D, 16'h0000, 3'd0, 1'b1, 1'b0);
    check("t1.value", 32'(value), 32'h1AF3);
    idle("t1");
    check("t1.hold", 32'(value), 32'h1AF3);

    // backspace
    step("t2.7",  "7",   16'h0007, 3'd1, 1'b0, 1'b0);
    step("t2.B",  "B",   16'h007B, 3'd2, 1'b0, 1'b0);
    step("t2.bs", 8'h08, 16'h0007, 3'd1, 1'b0, 1'b0);
    step("t2.C",  "C",   16'h007C, 3'd2, 1'b0, 1'b0);
    step("t2.cr", 8'h0D, 16'h0000, 3'd0, 1'b1, 1'b0);
    check("t2.value", 32'(value), 32'h007C);

    // overflow: fifth digit freezes, backspace ignored, CR reports error
    step("t3.1",  "1",   16'h0001, 3'd1, 1'b0, 1'b0);
    step("t3.2",  "2",   16'h0012, 3'd2, 1'b0, 1'b0);
    step("t3.3",  "3",   16'h0123, 3'd3, 1'b0, 1'b0);
    step("t3.4",  "4",   16'h1234, 3'd4, 1'b0, 1'b0);
    step("t3.5",  "5",   16'h1234, 3'd4, 1'b0, 1'b0);
    step("t3.bs", 8'h08, 16'h1234, 3'd4, 1'b0, 1'b0);
    step("t3.q",  "?",   16'h1234, 3'd4, 1'b0, 1'b1);
    step("t3.cr", 8'h0D, 16'h0000, 3'd0, 1'b0, 1'b1);
    check("t3.value", 32'(value), 32'h007C);
    idle("t3");

    // illegal characters, including range edges '@' and 'g'
    step("t4.G",  "G",   16'h0000, 3'd0, 1'b0, 1'b1);
    step("t4.at", "@",   16'h0000, 3'd0, 1'b0, 1'b1);
    step("t4.9",  "9",   16'h0009, 3'd1, 1'b0, 1'b0);
    step("t4.z",  "z",   16'h0009, 3'd1, 1'b0, 1'b1);
    step("t4.g",  "g",   16'h0009, 3'd1, 1'b0, 1'b1);
    step("t4.cr", 8'h0D, 16'h0000, 3'd0, 1'b1, 1'b0);
    check("t4.value", 32'(value), 32'h0009);

    // ignored controls in EMPTY, escape, backspace down to empty
    step("t5.cr0", 8'h0D, 16'h0000, 3'd0, 1'b0, 1'b0);
    step("t5.bs0", 8'h08, 16'h0000, 3'd0, 1'b0, 1'b0);
    step("t5.5",   "5",   16'h0005, 3'd1, 1'b0, 1'b0);
    step("t5.esc", 8'h1B, 16'h0000, 3'd0, 1'b0, 1'b0);
    step("t5.cr1", 8'h0D, 16'h0000, 3'd0, 1'b0, 1'b0);
    step("t5.3",   "3",   16'h0003, 3'd1, 1'b0, 1'b0);
    step("t5.bs1", 8'h08, 16'h0000, 3'd0, 1'b0, 1'b0);
    step("t5.cr2", 8'h0D, 16'h0000, 3'd0, 1'b0, 1'b0);
    check("t5.value", 32'(value), 32'h0009);

    // leading zeros and the lowercase/uppercase upper bounds; CR then digit back-to-back
    step("t6.0",  "0",   16'h0000, 3'd1, 1'b0, 1'b0);
    step("t6.f",  "f",   16'h000F, 3'd2, 1'b0, 1'b0);
    step("t6.cr", 8'h0D, 16'h0000, 3'd0, 1'b1, 1'b0);
    check("t6.value", 32'(value), 32'h000F);
    step("t6.A",  "A",   16'h000A, 3'd1, 1'b0, 1'b0);
    step("t6.cr2", 8'h0D, 16'h0000, 3'd0, 1'b1, 1'b0);
    check("t6.value2", 32'(value), 32'h000A);

    // reset mid-entry with a character presented the same cycle
    step("t7.4", "4", 16'h0004, 3'd1, 1'b0, 1'b0);
    step("t7.2", "2", 16'h0042, 3'd2, 1'b0, 1'b0);
    rst        = 1'b1;
    char_in    = 8'h0D;
    char_valid = 1'b1;
    @(negedge clk);
    check("t7.rst.value", 32'(value), 32'h0);
    check("t7.rst.partial", 32'(partial), 32'h0);
    check("t7.rst.cnt", 32'(digit_cnt), 32'h0);
    check("t7.rst.vv", 32'(value_valid), 32'h0);
    check("t7.rst.err", 32'(err), 32'h0);
    rst = 1'b0;
    step("t7.8",  "8",   16'h0008, 3'd1, 1'b0, 1'b0);
    step("t7.cr", 8'h0D, 16'h0000, 3'd0, 1'b1, 1'b0);
    check("t7.value", 32'(value), 32'h0008);
    idle("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ascii2bin_parser.md
Name: ascii2bin_parser

Overview:
Sequential ASCII-hex-to-binary parser for the keyboard path, the inverse of the existing binary-to-ASCII display converter. It consumes one ASCII character per valid strobe from the keyboard decoder and accumulates up to NDIGITS hex digits into a binary word. On a terminator character it emits the word with a one-cycle valid pulse. It supports backspace, escape-clear and overflow/illegal-character error reporting, and sits between the keyboard scan-code-to-ASCII stage and the control logic that consumes the entered values.

Parameters:
NDIGITS, 4, maximum hex digits accepted; output width is 4*NDIGITS.
TERM_CHAR, 8'h0D, terminator (Enter); commits the value.
BKSP_CHAR, 8'h08, backspace; removes the last digit.
ESC_CHAR, 8'h1B, escape; discards the entry.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
char_in  in  8  ASCII character from the keyboard decoder
char_valid  in  1  char_in is valid this cycle; one character per asserted cycle; no backpressure
value  out  4*NDIGITS  last committed value; holds until the next commit
value_valid  out  1  one-cycle pulse; value updated this cycle
err  out  1  one-cycle pulse on illegal character or overflow commit
partial  out  4*NDIGITS  live accumulator, for echo to the display
digit_cnt  out  3  digits currently held, 0..NDIGITS

Behaviour:
- Reset (rst=1 at a clk edge):
  - value=0, partial=0, digit_cnt=0, value_valid=0, err=0, state=EMPTY.
  - Reset wins over a same-cycle char_valid.
  - Reset mid-entry discards the entry with no pulses.
- Character classification (combinational):
  - '0'-'9' (0x30-0x39) -> nibble = c-0x30.
  - 'A'-'F' (0x41-0x46) -> nibble = c-0x37.
  - 'a'-'f' (0x61-0x66) -> nibble = c-0x57.
  - TERM / BKSP / ESC as parameterised.
  - Anything else is illegal.
- Cycles with char_valid=0 change nothing; the pulses deassert.
- State EMPTY (digit_cnt=0):
  - digit -> partial=nibble, cnt=1, go to ENTRY.
  - TERM -> ignored; no pulse, value unchanged.
  - BKSP, ESC -> ignored.
  - illegal -> err pulse; stay in EMPTY.
- State ENTRY (1..NDIGITS digits):
  - digit, cnt<NDIGITS -> partial={partial[4*NDIGITS-5:0],nibble}, cnt+1.
  - digit, cnt==NDIGITS -> go to OVERFLOW; partial and cnt are frozen.
  - BKSP -> partial=partial>>4, cnt-1; go to EMPTY when cnt becomes 0.
  - TERM -> value<=partial with value_valid=1 in the next cycle (latency 1 clk after the accepting edge); then partial=0, cnt=0, go to EMPTY.
  - ESC -> partial=0, cnt=0, go to EMPTY; no pulse.
  - illegal -> err pulse; the character is dropped and the entry kept.
- State OVERFLOW:
  - digits and BKSP are ignored.
  - TERM -> err pulse, no value_valid, value unchanged; clear and go to EMPTY.
  - ESC -> clear and go to EMPTY with no pulse.
  - illegal -> err pulse; stay in OVERFLOW.
- value_valid and err are never asserted in the same cycle. Both are registered and both are 1-cycle wide.
- Back-to-back characters on consecutive cycles are fully supported: a TERM followed immediately by a digit starts a new entry in the next cycle.
- Leading zeros count as digits. Width is exact: no sign handling and no saturation.

Decomposition:
- Shared keyboard package/header holds:
  - ASCII constants CHAR_CR, CHAR_BS, CHAR_ESC, CHAR_0, CHAR_A, CHAR_a.
  - State encodings ST_EMPTY, ST_ENTRY, ST_OVERFLOW (2-bit).
- One natural combinational sub-module, ascii_hex_decode: char_in -> {is_digit, nibble[3:0], is_term, is_bksp, is_esc, is_illegal}. It is reusable by other keyboard consumers.
- The FSM, accumulator and output registers live in the top.

Test Plan:
- Reset, then '1','a','F','3',CR on consecutive cycles -> value_valid pulses once, value=16'h1AF3, digit_cnt returns to 0, err never asserted.
- '7','B',BKSP,'C',CR -> partial sequence 0x7, 0x7B, 0x7, 0x7C; value=16'h007C committed.
- '1','2','3','4','5',CR -> entry enters OVERFLOW on '5'; CR gives an err pulse, no value_valid, value keeps its prior 16'h007C.
- 'G' in EMPTY and '9','z' in ENTRY -> err pulse on each illegal; the next CR commits value=16'h0009.
- CR alone in EMPTY, and '5',ESC,CR -> no value_valid, no err, partial=0 after ESC.
- rst asserted after '4','2' with char_valid high the same cycle -> all outputs zero, state EMPTY; a following '8',CR yields value=16'h0008.
